// File: rtl/xbar_read_return_arbiter.sv
// Per-master read-data return arbiter: round-robin over slaves whose front beat targets this master.
// Burst locking until RLAST is enabled by defining XBAR_RRET_BURST_LOCK_EN.
module xbar_read_return_arbiter #(
   parameter int masters            = 2,
   parameter int slaves             = 2,
   parameter int i_am_master_number = 0,
   parameter int LEN_WIDTH          = 4
) (
   input  logic                       ACLK,
   input  logic                       ARESET,
   input  logic                       slave_fifo_empty  [0:slaves-1],
   input  logic [$clog2(masters)-1:0] slave_dest_master [0:slaves-1],
   input  logic                       slave_rlast       [0:slaves-1],
   input  logic                       master_fifo_full,
   output logic [$clog2(slaves)-1:0]  grant_slave_number,
   output logic                       push_to_fifo,
   output logic                       transfer,
   output logic                       burst_active,
   output logic [LEN_WIDTH:0]         beat_count
);

   localparam int SW = $clog2(slaves);
   localparam int MW = $clog2(masters);
   localparam logic [MW-1:0]      MY_ID      = MW'(i_am_master_number);
   localparam logic [SW-1:0]      LAST_SLAVE = SW'(slaves - 1);
   localparam logic [LEN_WIDTH:0] BEAT_MAX   = {(LEN_WIDTH+1){1'b1}};
   localparam logic [LEN_WIDTH:0] BEAT_ZERO  = {(LEN_WIDTH+1){1'b0}};
   localparam logic [LEN_WIDTH:0] BEAT_ONE   = (LEN_WIDTH+1)'(1);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_BURST = 1'b1;

   logic [0:0]         state_q, state_d;
   logic [SW-1:0]      rr_q, rr_d;
   logic [SW-1:0]      lock_q, lock_d;
   logic [LEN_WIDTH:0] beat_q, beat_d;

   logic [slaves-1:0]  req_s;
   logic               rr_found_s;
   logic [SW-1:0]      rr_pick_s;
   logic               grant_rlast_s;

   function automatic logic [SW-1:0] wrap_inc(input logic [SW-1:0] s);
      if (s == LAST_SLAVE) begin
         return {SW{1'b0}};
      end else begin
         return s + 1'b1;
      end
   endfunction

   function automatic logic [LEN_WIDTH:0] sat_inc(input logic [LEN_WIDTH:0] c);
      if (c == BEAT_MAX) begin
         return c;
      end else begin
         return c + BEAT_ONE;
      end
   endfunction

   // Request vector: slave has a beat and that beat is for this master
   always_comb begin
      req_s = {slaves{1'b0}};
      for (int s = 0; s < slaves; s++) begin
         req_s[s] = ~slave_fifo_empty[s] & (slave_dest_master[s] == MY_ID);
      end
   end

   // Round-robin search starting at rr_q, wrapping at the last slave
   always_comb begin
      int            idx;
      logic [SW-1:0] cand;
      rr_found_s = 1'b0;
      rr_pick_s  = rr_q;
      for (int i = 0; i < slaves; i++) begin
         idx = int'(rr_q) + i;
         if (idx >= slaves) begin
            idx = idx - slaves;
         end else begin
            idx = idx;
         end
         cand = SW'(idx);
         if (!rr_found_s && req_s[cand]) begin
            rr_found_s = 1'b1;
            rr_pick_s  = cand;
         end else begin
            rr_found_s = rr_found_s;
         end
      end
   end

   // Grant mux: locked slave during a burst, round-robin winner otherwise
   always_comb begin
      if (state_q == ST_BURST) begin
         grant_slave_number = lock_q;
         push_to_fifo       = req_s[lock_q];
      end else begin
         grant_slave_number = rr_pick_s;
         push_to_fifo       = rr_found_s;
      end
      transfer      = push_to_fifo & ~master_fifo_full;
      grant_rlast_s = slave_rlast[grant_slave_number];
   end

   // Next-state: everything holds unless a beat actually moves
   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      lock_d  = lock_q;
      beat_d  = beat_q;
      if (transfer) begin
         if (state_q == ST_BURST) begin
            if (grant_rlast_s) begin
               state_d = ST_IDLE;
               rr_d    = wrap_inc(lock_q);
               beat_d  = BEAT_ZERO;
            end else begin
               beat_d  = sat_inc(beat_q);
            end
         end else begin
`ifdef XBAR_RRET_BURST_LOCK_EN
            if (grant_rlast_s) begin
               rr_d    = wrap_inc(grant_slave_number);
               beat_d  = BEAT_ZERO;
            end else begin
               lock_d  = grant_slave_number;
               state_d = ST_BURST;
               beat_d  = BEAT_ONE;
            end
`else
            // No locking: every beat is treated as a complete transaction for fairness
            rr_d = wrap_inc(grant_slave_number);
            if (grant_rlast_s) begin
               beat_d = BEAT_ZERO;
            end else begin
               beat_d = sat_inc(beat_q);
            end
`endif
         end
      end else begin
         beat_d = beat_q;
      end
   end

   // State registers with asynchronous reset
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q <= ST_IDLE;
         rr_q    <= {SW{1'b0}};
         lock_q  <= {SW{1'b0}};
         beat_q  <= BEAT_ZERO;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         lock_q  <= lock_d;
         beat_q  <= beat_d;
      end
   end

   assign burst_active = (state_q == ST_BURST);
   assign beat_count   = beat_q;

endmodule

// File: tb/tb_xbar_read_return_arbiter.sv
// Randomized + directed bench for xbar_read_return_arbiter (3 slaves, serving master 1).
module tb_xbar_read_return_arbiter;

   localparam int S    = 3;
   localparam int M    = 2;
   localparam int ME   = 1;
   localparam int LW   = 4;
   localparam int CMAX = 31;
`ifdef XBAR_RRET_BURST_LOCK_EN
   localparam bit LOCK = 1'b1;
`else
   localparam bit LOCK = 1'b0;
`endif

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic        empty [0:S-1];
   logic [0:0]  dest  [0:S-1];
   logic        rlast [0:S-1];
   logic        full;
   logic [1:0]  grant;
   logic        push, xfer, bact;
   logic [LW:0] bcnt;

   int checks = 0;
   int passed = 0;

   // reference model state
   int m_rr, m_lock, m_cnt;
   bit m_burst;
   int e_grant;
   bit e_push, e_xfer;

   always #5 ACLK = ~ACLK;

   xbar_read_return_arbiter #(
      .masters(M), .slaves(S), .i_am_master_number(ME), .LEN_WIDTH(LW)
   ) u_dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .slave_fifo_empty(empty), .slave_dest_master(dest), .slave_rlast(rlast),
      .master_fifo_full(full),
      .grant_slave_number(grant), .push_to_fifo(push), .transfer(xfer),
      .burst_active(bact), .beat_count(bcnt)
   );

   function automatic bit req(input int s);
      return !empty[s] && (int'(dest[s]) == ME);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_rr = 0; m_lock = 0; m_cnt = 0; m_burst = 1'b0;
   endtask

   task automatic model_eval();
      e_push  = 1'b0;
      e_grant = m_rr;
      if (m_burst) begin
         e_grant = m_lock;
         e_push  = req(m_lock);
      end else begin
         for (int k = 0; k < S; k++) begin
            if (!e_push && req((m_rr + k) % S)) begin
               e_grant = (m_rr + k) % S;
               e_push  = 1'b1;
            end
         end
      end
      e_xfer = e_push && !full;
   endtask

   task automatic model_clock();
      if (e_xfer) begin
         if (m_burst) begin
            if (rlast[e_grant]) begin
               m_burst = 1'b0; m_rr = (e_grant + 1) % S; m_cnt = 0;
            end else begin
               m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
            end
         end else if (LOCK && !rlast[e_grant]) begin
            m_burst = 1'b1; m_lock = e_grant; m_cnt = 1;
         end else begin
            m_rr  = (e_grant + 1) % S;
            m_cnt = rlast[e_grant] ? 0 : ((m_cnt < CMAX) ? m_cnt + 1 : CMAX);
         end
      end
   endtask

   // one clock: compare outputs against the model, then advance both across the edge
   task automatic cycle(input string tag);
      #1;
      model_eval();
      chk({tag, ".grant"}, 32'(grant), 32'(e_grant));
      chk({tag, ".push"},  32'(push),  32'(e_push));
      chk({tag, ".xfer"},  32'(xfer),  32'(e_xfer));
      chk({tag, ".bact"},  32'(bact),  32'(m_burst));
      chk({tag, ".bcnt"},  32'(bcnt),  32'(m_cnt));
      @(posedge ACLK);
      model_clock();
      #1;
   endtask

   task automatic set_slave(input int s, input bit valid, input int d, input bit last);
      empty[s] = !valid;
      dest[s]  = 1'(d);
      rlast[s] = last;
   endtask

   task automatic all_empty();
      for (int s = 0; s < S; s++) set_slave(s, 1'b0, ME, 1'b0);
   endtask

   initial begin
      int sent, stall;
      ARESET = 1'b1;
      full   = 1'b0;
      all_empty();
      model_reset();
      @(posedge ACLK); #1;

      // 1: reset state with no requests
      chk("t1.grant", 32'(grant), 32'd0);
      chk("t1.push",  32'(push),  32'd0);
      chk("t1.xfer",  32'(xfer),  32'd0);
      chk("t1.bact",  32'(bact),  32'd0);
      chk("t1.bcnt",  32'(bcnt),  32'd0);
      ARESET = 1'b0;
      cycle("t1.idle");

      // 2: two single-beat requests drain in order
      set_slave(0, 1'b1, ME, 1'b1);
      set_slave(1, 1'b1, ME, 1'b1);
      cycle("t2.a");
      set_slave(0, 1'b0, ME, 1'b1);
      cycle("t2.b");
      all_empty();
      cycle("t2.c");

      // 3: 4-beat burst from slave 0 while slave 1 keeps requesting
      sent = 0;
      for (int g = 0; g < 20 && sent < 4; g++) begin
         set_slave(0, 1'b1, ME, sent == 3);
         set_slave(1, 1'b1, ME, 1'b1);
         cycle("t3.burst");
         if (e_xfer && e_grant == 0) sent++;
      end
      chk("t3.beats", 32'(sent), 32'd4);
      set_slave(0, 1'b0, ME, 1'b0);
      cycle("t3.after");
      all_empty();
      cycle("t3.idle");

      // 4: master FIFO full for 3 cycles in the middle of a burst from slave 2
      sent = 0; stall = 0;
      for (int g = 0; g < 30 && sent < 5; g++) begin
         set_slave(2, 1'b1, ME, sent == 4);
         set_slave(1, 1'b1, ME, 1'b1);
         full = (sent == 2 && stall < 3);
         if (full) stall++;
         cycle("t4.burst");
         if (e_xfer && e_grant == 2) sent++;
      end
      chk("t4.beats", 32'(sent), 32'd5);
      chk("t4.stall", 32'(stall), 32'd3);
      full = 1'b0;
      all_empty();
      cycle("t4.idle");

      // 5: slave 0 front beat is for the other master
      set_slave(0, 1'b1, 1 - ME, 1'b1);
      set_slave(1, 1'b1, ME, 1'b1);
      cycle("t5.a");
      set_slave(1, 1'b0, ME, 1'b1);
      cycle("t5.b");
      all_empty();
      cycle("t5.c");

      // 6: asynchronous reset after 2 beats of a burst from slave 0
      sent = 0;
      for (int g = 0; g < 10 && sent < 2; g++) begin
         set_slave(0, 1'b1, ME, 1'b0);
         cycle("t6.burst");
         if (e_xfer && e_grant == 0) sent++;
      end
      ARESET = 1'b1;
      #1;
      model_reset();
      chk("t6.grant", 32'(grant), 32'd0);
      chk("t6.bact",  32'(bact),  32'd0);
      chk("t6.bcnt",  32'(bcnt),  32'd0);
      @(posedge ACLK); #1;
      ARESET = 1'b0;
      set_slave(0, 1'b1, ME, 1'b1);
      cycle("t6.rearb");
      all_empty();
      cycle("t6.idle");

      // 7: long burst drives beat_count to saturation
      sent = 0;
      for (int g = 0; g < 60 && sent < 40; g++) begin
         set_slave(1, 1'b1, ME, sent == 39);
         cycle("t7.sat");
         if (e_xfer) sent++;
      end
      chk("t7.beats", 32'(sent), 32'd40);
      all_empty();
      cycle("t7.idle");

      // 8: random traffic
      for (int n = 0; n < 600; n++) begin
         for (int s = 0; s < S; s++) begin
            set_slave(s, $urandom_range(0, 3) != 0, $urandom_range(0, 1),
                      $urandom_range(0, 3) == 0);
         end
         full = ($urandom_range(0, 4) == 0);
         cycle("t8.rand");
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/xbar_read_return_arbiter.md
# xbar_read_return_arbiter

- Per-master arbiter for the read-data return path of the crossbar.
- Selects which slave-side read-data FIFO drains into this master's read-data FIFO, using round-robin among slaves whose front beat is addressed to this master.
- Optionally holds the grant for a whole burst until the RLAST beat transfers.
- One instance per master; its grant and push outputs drive the per-slave read-data pop logic.

## Interface

Parameters:
- `masters`, 2: number of masters (≥2).
- `slaves`, 2: number of slaves (≥2; need not be a power of two).
- `i_am_master_number`, 0: master index this instance serves.
- `LEN_WIDTH`, 4: AXI burst length width; sizes the beat counter.

Ports:
- `ACLK` in 1: clock.
- `ARESET` in 1: reset, asynchronous, active-high.
- `slave_fifo_empty` in [0:slaves-1] x 1: slave read-data FIFO empty flags.
- `slave_dest_master` in [0:slaves-1] x $clog2(masters): decoded destination master of each slave's front beat.
- `slave_rlast` in [0:slaves-1] x 1: RLAST of each slave's front beat.
- `master_fifo_full` in 1: this master's read-data FIFO is full.
- `grant_slave_number` out $clog2(slaves): currently granted slave.
- `push_to_fifo` out 1: the grant is valid; this cycle's beat from the granted slave is requested.
- `transfer` out 1: a beat moves this cycle.
- `burst_active` out 1: FSM is in BURST.
- `beat_count` out LEN_WIDTH+1: beats transferred in the current burst.

## Operation

- `req[s] = ~slave_fifo_empty[s] & (slave_dest_master[s] == i_am_master_number)`.
- `transfer = push_to_fifo & ~master_fifo_full`.
  - Since `push_to_fifo` implies `req[grant]`, `transfer` means a beat moves this cycle.
- Registered state:
  - `rr_ptr`, $clog2(slaves) bits.
  - `lock_slave`, $clog2(slaves) bits.
  - FSM with states IDLE and BURST.
  - `beat_count`.

IDLE:
- `grant_slave_number` is the first `s` with `req[s]`, searching `rr_ptr`, `rr_ptr+1`, … with wrap from `slaves-1` to 0.
- If no `req`: `grant_slave_number = rr_ptr` and `push_to_fifo = 0`. Otherwise `push_to_fifo = 1`.
- On `transfer` with `slave_rlast[grant]=1`:
  - `rr_ptr <= grant+1` (wrapped).
  - Stay in IDLE; `beat_count <= 0`.
- On `transfer` with `slave_rlast[grant]=0`:
  - `lock_slave <= grant`.
  - Go to BURST; `beat_count <= 1`.

BURST:
- `grant_slave_number = lock_slave`; `push_to_fifo = req[lock_slave]`.
- Other slaves are ignored even when requesting.
- On `transfer` with `slave_rlast[lock_slave]=0`: `beat_count <= beat_count+1`, saturating at all-ones.
- On `transfer` with `slave_rlast[lock_slave]=1`:
  - Go to IDLE.
  - `rr_ptr <= lock_slave+1` (wrapped).
  - `beat_count <= 0`.
- If `req[lock_slave]` drops (FIFO empty or front beat for another master) or `master_fifo_full=1`: stall in BURST, no transfer.

`burst_active = (state == BURST)`.

## Timing

- `grant_slave_number`, `push_to_fifo` and `transfer` are combinational from the current inputs and registered state; zero-cycle grant.
- State, `rr_ptr`, `lock_slave` and `beat_count` update on the rising edge of `ACLK` only when `transfer=1`.
- Reset (asynchronous, immediate, also mid-burst):
  - State is IDLE; `rr_ptr=0`, `lock_slave=0`, `beat_count=0`.
  - Outputs become `grant_slave_number=0`, `burst_active=0`.
  - `push_to_fifo` and `transfer` then follow the IDLE rule with `rr_ptr=0` (both 0 when no slave requests).
  - An interrupted burst is abandoned; the arbiter re-arbitrates on the first post-reset cycle.
- Single-beat burst (RLAST on first beat): no BURST entry; `rr_ptr` advances the same cycle.
- Back-to-back bursts with no idle cycle are allowed.
- `master_fifo_full` has priority: no state change while full.

## Configuration

- `XBAR_RRET_BURST_LOCK_EN` defined: burst locking as above.
- Undefined:
  - The FSM never leaves IDLE.
  - Every transfer advances `rr_ptr <= grant+1` regardless of `slave_rlast`.
  - `burst_active=0` constant.
  - `beat_count` counts 1 per transfer and clears when the transferred beat has `slave_rlast=1`.
  - This mode is for write-response channel reuse, where every beat is final (drive `slave_rlast` high).

## Test plan

1. Reset, slaves=2, no requests → `grant_slave_number=0`, `push_to_fifo=0`, `transfer=0`, `burst_active=0`, `beat_count=0`.
2. Slave0 and slave1 each hold one beat with RLAST for this master, `master_fifo_full=0` → cycle 0 grants 0 with `transfer`; cycle 1 grants 1 with `transfer`; then `rr_ptr=0`.
3. Lock enabled:
   - Stimulus: slave0 has a 4-beat burst (RLAST on beat 4) and slave1 requests throughout.
   - Required: grant stays 0 for 4 transfers; `beat_count` goes 1, 2, 3, then clears to 0 on the beat-4 transfer; slave1 is granted the next cycle.
4. Mid-burst `master_fifo_full=1` for 3 cycles → `transfer=0`, `grant` and `beat_count` hold; the burst resumes when `master_fifo_full` drops.
5. Slave0's front beat is addressed to another master while slave1 requests → grant 1 and `transfer`; `rr_ptr` advances to 0.
6. slaves=3, `rr_ptr=2`, and `ARESET` pulses in BURST after 2 beats → immediately IDLE, `beat_count=0`, `rr_ptr=0`, `grant=0`.
